// File: rtl/mic_pair_packer.sv
// Pairs two microphone sample streams into {ch1, ch0} words with framing.
// Each channel has its own FIFO. A word is emitted only when both channels hold a sample.
module mic_pair_packer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_LEN    = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [SAMPLE_WIDTH-1:0]   ch0_TDATA,
    input  logic                      ch0_TVALID,
    output logic                      ch0_TREADY,
    input  logic [SAMPLE_WIDTH-1:0]   ch1_TDATA,
    input  logic                      ch1_TVALID,
    output logic                      ch1_TREADY,
    output logic [2*SAMPLE_WIDTH-1:0] stream_out_TDATA,
    output logic                      stream_out_TVALID,
    input  logic                      stream_out_TREADY,
    output logic                      stream_out_TLAST,
    output logic [15:0]               frame_count,
    output logic                      desync,
    input  logic                      clear_desync
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_LEN - 1);

    logic [SAMPLE_WIDTH-1:0] r_mem0 [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] r_mem1 [FIFO_DEPTH];
    logic [AW:0]             r_wp0, r_rp0, r_wp1, r_rp1;
    logic                    r_rdy_en;
    logic [CW-1:0]           r_word;
    logic [15:0]             r_frames;
    logic                    r_desync;

    logic [AW:0] w_cnt0, w_cnt1;
    logic        w_full0, w_full1, w_empty0, w_empty1;
    logic        w_push0, w_push1, w_valid, w_last, w_pop;

    always_comb begin
        w_cnt0   = r_wp0 - r_rp0;
        w_cnt1   = r_wp1 - r_rp1;
        w_full0  = (w_cnt0 == FULL_CNT);
        w_full1  = (w_cnt1 == FULL_CNT);
        w_empty0 = (r_wp0 == r_rp0);
        w_empty1 = (r_wp1 == r_rp1);
    end

    // Ready stays low through reset and rises on the first edge afterwards.
    assign ch0_TREADY = r_rdy_en & ~w_full0;
    assign ch1_TREADY = r_rdy_en & ~w_full1;
    assign w_push0    = ch0_TVALID & ch0_TREADY;
    assign w_push1    = ch1_TVALID & ch1_TREADY;

    assign w_valid = ~w_empty0 & ~w_empty1;
    assign w_last  = w_valid & (r_word == LAST_WORD);
    assign w_pop   = w_valid & stream_out_TREADY;

    // Data is gated by valid so the output bus reads zero whenever nothing is offered.
    assign stream_out_TVALID = w_valid;
    assign stream_out_TLAST  = w_last;
    assign stream_out_TDATA  = w_valid ? {r_mem1[r_rp1[AW-1:0]], r_mem0[r_rp0[AW-1:0]]} : '0;
    assign frame_count       = r_frames;
    assign desync            = r_desync;

    always_ff @(posedge ap_clk) begin
        if (w_push0) r_mem0[r_wp0[AW-1:0]] <= ch0_TDATA;
        if (w_push1) r_mem1[r_wp1[AW-1:0]] <= ch1_TDATA;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wp0    <= '0;
            r_rp0    <= '0;
            r_wp1    <= '0;
            r_rp1    <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push0) r_wp0 <= r_wp0 + 1'b1;
            if (w_push1) r_wp1 <= r_wp1 + 1'b1;
            if (w_pop) begin
                r_rp0 <= r_rp0 + 1'b1;
                r_rp1 <= r_rp1 + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_word   <= '0;
            r_frames <= '0;
        end else if (w_pop) begin
            r_word <= w_last ? '0 : r_word + 1'b1;
            if (w_last) r_frames <= r_frames + 16'd1;
        end
    end

    // A full FIFO facing an empty one means the channels have skewed; set beats clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_desync <= 1'b0;
        end else if ((w_full0 && w_empty1) || (w_full1 && w_empty0)) begin
            r_desync <= 1'b1;
        end else if (clear_desync) begin
            r_desync <= 1'b0;
        end
    end

endmodule

// File: doc/mic_pair_packer.md
MIC_PAIR_PACKER -- requirements
Module: mic_pair_packer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 32, meaning per-channel sample width (IEEE-754 single).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning per-channel FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter FRAME_LEN, default 1024, meaning paired words per frame (at least 2).
REQ-004 SHALL use one clock and an asynchronous active-low reset: ap_clk  in  1  clock, all logic on rising edge.
REQ-005 ap_rst_n  in  1  asynchronous active-low reset.
REQ-006 ch0_TDATA  in  SAMPLE_WIDTH  microphone 0 sample.
REQ-007 ch0_TVALID  in  1  ch0 sample valid.
REQ-008 ch0_TREADY  out  1  ch0 sample accepted.
REQ-009 ch1_TDATA / ch1_TVALID / ch1_TREADY  in/in/out  SAMPLE_WIDTH/1/1  microphone 1 stream, same semantics as ch0.
REQ-010 stream_out_TDATA  out  2*SAMPLE_WIDTH  paired word {ch1, ch0}, ch0 in the low half; feeds the gcc_phat stream_in port.
REQ-011 stream_out_TVALID  out  1  paired word valid.
REQ-012 stream_out_TREADY  in  1  downstream accepts.
REQ-013 stream_out_TLAST  out  1  high on the last word of each frame.
REQ-014 frame_count  out  16  completed frames, wrapping.
REQ-015 desync  out  1  sticky channel-skew error flag.
REQ-016 clear_desync  in  1  synchronous clear of desync.

Function
REQ-017 SHALL hold one FIFO per channel; push on chN_TVALID and chN_TREADY; chN_TREADY = FIFO not full, independent of pop in the same cycle (no full-FIFO pass-through).
REQ-018 SHALL assert stream_out_TVALID exactly when both FIFOs are non-empty; TDATA = {ch1 head, ch0 head}.
REQ-019 SHALL pop both FIFOs together on stream_out_TVALID and stream_out_TREADY; never pop one channel alone.
REQ-020 SHALL present a sample pushed at edge k on the output from just after edge k (one-cycle latency) when the other channel's head is already present.
REQ-021 SHALL hold TDATA, TLAST and TVALID stable while TVALID is high and TREADY is low.
REQ-022 SHALL keep a word counter 0..FRAME_LEN-1 that advances on each output transfer; TLAST = (counter == FRAME_LEN-1); the counter wraps to 0 on that transfer.
REQ-023 SHALL increment frame_count on each transfer with TLAST high; 65535 wraps to 0.
REQ-024 SHALL set desync at an edge where one FIFO is full and the other is empty; clear on clear_desync; set wins when both occur in the same cycle.
REQ-025 SHALL keep both FIFO occupancies at or below FIFO_DEPTH; simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.

Reset
REQ-026 While ap_rst_n is low, SHALL empty both FIFOs, zero the word counter and frame_count, and clear desync.
REQ-027 While ap_rst_n is low, SHALL drive TVALID, TLAST, ch0_TREADY and ch1_TREADY to 0 and TDATA to 0.
REQ-028 SHALL discard words in flight when reset asserts mid-frame; after deassert, the first transfer is word 0 of a new frame.
REQ-029 SHALL raise chN_TREADY on the first edge after deassert.

Verification
REQ-030 Reset, then ch0=0x3F800000 and ch1=0x40000000 valid in one cycle with TREADY=1 -> next cycle TVALID=1, TDATA=0x400000003F800000; popped on that edge.
REQ-031 ch0 only driven for 4 cycles (DEPTH=4), ch1 idle -> ch0_TREADY=0 after 4 pushes, desync=1, TVALID=0; then 4 ch1 pushes -> 4 transfers in order, desync remains 1 until clear_desync.
REQ-032 FRAME_LEN=4, 9 paired words with TREADY=1 -> TLAST on words 4 and 8, frame_count=2, word counter=1.
REQ-033 TREADY=0 for 10 cycles with both FIFOs full -> TDATA stable, both TREADY=0, no loss; release -> FIFO order preserved.
REQ-034 ap_rst_n low at word 2 of a frame -> outputs 0 immediately; after release, the next transfer has TLAST only at word FRAME_LEN-1 and frame_count=0.
REQ-035 Random valid/ready on all three ports, 10^5 cycles -> output equals in-order zip of both inputs; no drop, duplicate or reorder.
